// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
//
// Fetch-stage program counter with a circular return-address stack (RAS).
//
// The registered fetch PC advances by one of four sources each enabled cycle:
// sequential increment, taken branch/jump target, call target, or the
// return address predicted by the RAS. A pipeline redirect overrides
// everything (including stall) and squashes any RAS push/pop of the
// redirected instruction. ras_flush empties the stack whatever else happens.
//
// Parameters
//   PC_W       width of the PC and all address ports
//   RESET_PC   PC value loaded by RST
//   INC        sequential increment added to PC
//   RAS_DEPTH  number of RAS entries (power of two, >= 2)
//   CNT_W      derived width of ras_count (not overridable)
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   synchronous reset, active-high
//   pc_en        in   advance PC this cycle (0 = stall)
//   redirect_en  in   force PC to redirect_pc; highest priority
//   redirect_pc  in   redirect target
//   ras_flush    in   empty the RAS this cycle
//   branch_en    in   taken branch/jump; next PC = target_pc
//   call_en      in   call; push PC+INC, next PC = target_pc
//   ret_en       in   return; pop RAS, next PC = predicted address
//   target_pc    in   decoded target; fallback for a return on an empty RAS
//   PC           out  current fetch PC (registered)
//   npc          out  PC+INC (combinational from PC only)
//   ras_top      out  entry at top of stack, 0 when empty
//   ras_count    out  number of valid entries, 0..RAS_DEPTH
//   ras_empty    out  ras_count == 0
//   ras_ovf      out  sticky: a push happened while the stack was full
//   ras_unf      out  sticky: a pop happened while the stack was empty
// -----------------------------------------------------------------------------
module pc_ras_unit #(
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000,
  parameter int                INC       = 4,
  parameter int                RAS_DEPTH = 4,
  localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pc_en,
  input  logic             redirect_en,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             ras_flush,
  input  logic             branch_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [PC_W-1:0]  target_pc,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  npc,
  output logic [PC_W-1:0]  ras_top,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  // Stack operation requested by the instruction in fetch this cycle.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL   // call+ret on a non-empty stack: overwrite top in place
  } ras_op_e;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             unf_q;
  logic             full;
  logic             empty;
  logic [PC_W-1:0]  stack_q [RAS_DEPTH];

  ras_op_e          op;
  logic             set_unf;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // ---------------------------------------------------------------------------
  // Derived values
  // ---------------------------------------------------------------------------
  // Wraps naturally at 2^PC_W; depends on the PC register only.
  assign npc     = pc_q + PC_W'(INC);

  // RAS_DEPTH is a power of two, so pointer arithmetic wraps modulo depth.
  assign ptr_inc = ptr_q + 1'b1;
  assign ptr_dec = ptr_q - 1'b1;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));

  // ---------------------------------------------------------------------------
  // Next-PC selection and RAS operation decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block, so no path
  // through the if/else chain leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    op      = OP_NONE;
    set_unf = 1'b0;

    if (redirect_en) begin
      // Squashed instruction: its call/ret must not touch the stack.
      pc_d = redirect_pc;
    end else if (pc_en) begin
      if (ret_en && call_en) begin
        pc_d = target_pc;
        // On an empty stack there is no top to replace, so it becomes a push.
        op   = empty ? OP_PUSH : OP_REPL;
      end else if (ret_en) begin
        if (!empty) begin
          pc_d = ras_top;
          op   = OP_POP;
        end else begin
          pc_d    = target_pc;
          set_unf = 1'b1;
        end
      end else if (call_en) begin
        pc_d = target_pc;
        op   = OP_PUSH;
      end else if (branch_en) begin
        pc_d = target_pc;
      end else begin
        pc_d = npc;
      end
    end

    // A flush in the same cycle cancels any stack movement (and therefore
    // the event that would have set a sticky flag).
    if (ras_flush) begin
      op      = OP_NONE;
      set_unf = 1'b0;
    end
  end

  // Stack write port: a push writes the slot the pointer moves to, a
  // replace writes the current top slot.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (!RST) begin
      case (op)
        OP_PUSH: begin
          wr_en  = 1'b1;
          wr_idx = ptr_inc;
        end
        OP_REPL: begin
          wr_en  = 1'b1;
          wr_idx = ptr_q;
        end
        default: begin
          wr_en  = 1'b0;
          wr_idx = ptr_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC, pointer, count and sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;

      if (ras_flush) begin
        ptr_q   <= '0;
        count_q <= '0;
      end else begin
        case (op)
          OP_PUSH: begin
            ptr_q <= ptr_inc;
            if (full) begin
              // Oldest entry is overwritten; depth stays saturated.
              ovf_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          OP_POP: begin
            ptr_q   <= ptr_dec;
            count_q <= count_q - 1'b1;
          end
          default: begin
            ptr_q   <= ptr_q;
            count_q <= count_q;
          end
        endcase
      end

      if (set_unf) begin
        unf_q <= 1'b1;
      end
    end
  end

  // NOTE: the stack array is deliberately not reset; validity is tracked by
  // count_q, which keeps the storage a plain register file / RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      stack_q[wr_idx] <= npc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PC        = pc_q;
  assign ras_top   = empty ? '0 : stack_q[ptr_q];
  assign ras_count = count_q;
  assign ras_empty = empty;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ras_unit
//
// Directed scoreboard bench for pc_ras_unit (PC_W=32, RESET_PC=0, INC=4,
// RAS_DEPTH=4). Each step drives the inputs, queues the values the outputs
// must show after the next rising edge, then drains the queue against the
// DUT one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_pc_ras_unit;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum {F_PC, F_NPC, F_TOP, F_CNT, F_EMPTY, F_OVF, F_UNF} fld_e;

  typedef struct {
    fld_e        fld;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic             pc_en;
  logic             redirect_en;
  logic [PC_W-1:0]  redirect_pc;
  logic             ras_flush;
  logic             branch_en;
  logic             call_en;
  logic             ret_en;
  logic [PC_W-1:0]  target_pc;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  npc;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_ovf;
  logic             ras_unf;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  pc_ras_unit #(
    .PC_W      (PC_W),
    .RESET_PC  (32'h0000_0000),
    .INC       (4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc_en       (pc_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ras_flush   (ras_flush),
    .branch_en   (branch_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .target_pc   (target_pc),
    .PC          (PC),
    .npc         (npc),
    .ras_top     (ras_top),
    .ras_count   (ras_count),
    .ras_empty   (ras_empty),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input fld_e f);
    case (f)
      F_PC:    return PC;
      F_NPC:   return npc;
      F_TOP:   return ras_top;
      F_CNT:   return 32'(ras_count);
      F_EMPTY: return 32'(ras_empty);
      F_OVF:   return 32'(ras_ovf);
      F_UNF:   return 32'(ras_unf);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input fld_e f, input logic [31:0] v,
                            input string tag);
    exp_t e;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input bit redir,
                       input logic [31:0] rpc, input bit flush, input bit br,
                       input bit call, input bit ret, input logic [31:0] tgt);
    RST         = rst;
    pc_en       = en;
    redirect_en = redir;
    redirect_pc = rpc;
    ras_flush   = flush;
    branch_en   = br;
    call_en     = call;
    ret_en      = ret;
    target_pc   = tgt;
  endtask

  // Advance one edge, then compare everything queued for this step.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.fld), e.val);
    end
  endtask

  // Shorthands for the common step kinds.
  task automatic seq_step(input logic [31:0] exp_pc);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out(F_PC, exp_pc, "seq_pc");
    expect_out(F_NPC, exp_pc + 32'd4, "seq_npc");
    tick();
  endtask

  task automatic call_step(input logic [31:0] tgt, input logic [31:0] exp_top,
                           input int exp_cnt, input bit exp_ovf);
    drive(0, 1, 0, 0, 0, 0, 1, 0, tgt);
    expect_out(F_PC, tgt, "call_pc");
    expect_out(F_TOP, exp_top, "call_top");
    expect_out(F_CNT, 32'(exp_cnt), "call_cnt");
    expect_out(F_OVF, 32'(exp_ovf), "call_ovf");
    tick();
  endtask

  task automatic ret_step(input logic [31:0] tgt, input logic [31:0] exp_pc,
                          input int exp_cnt, input bit exp_unf);
    drive(0, 1, 0, 0, 0, 0, 0, 1, tgt);
    expect_out(F_PC, exp_pc, "ret_pc");
    expect_out(F_CNT, 32'(exp_cnt), "ret_cnt");
    expect_out(F_UNF, 32'(exp_unf), "ret_unf");
    tick();
  endtask

  task automatic redirect_to(input logic [31:0] rpc, input bit flush);
    drive(0, 1, 1, rpc, flush, 0, 0, 0, 0);
    expect_out(F_PC, rpc, "redir_pc");
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset state.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(F_PC, 32'h0, "rst_pc");
    expect_out(F_NPC, 32'h4, "rst_npc");
    expect_out(F_TOP, 32'h0, "rst_top");
    expect_out(F_CNT, 32'h0, "rst_cnt");
    expect_out(F_EMPTY, 32'h1, "rst_empty");
    expect_out(F_OVF, 32'h0, "rst_ovf");
    expect_out(F_UNF, 32'h0, "rst_unf");
    tick();

    // Sequential fetch.
    seq_step(32'h4);
    seq_step(32'h8);
    seq_step(32'hC);
    expect_out(F_EMPTY, 32'h1, "seq_empty");
    seq_step(32'h10);

    // Stall holds PC.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
      expect_out(F_PC, 32'h10, "stall_pc");
      tick();
    end

    // Redirect beats stall and squashes the call.
    drive(0, 0, 1, 32'h80, 0, 0, 1, 0, 32'h400);
    expect_out(F_PC, 32'h80, "redir_stall_pc");
    expect_out(F_CNT, 32'h0, "redir_stall_cnt");
    tick();

    // Taken branch; then branch+call follows the call rule.
    drive(0, 1, 0, 0, 0, 1, 0, 0, 32'h40);
    expect_out(F_PC, 32'h40, "branch_pc");
    expect_out(F_CNT, 32'h0, "branch_cnt");
    tick();
    drive(0, 1, 0, 0, 0, 1, 1, 0, 32'h60);
    expect_out(F_PC, 32'h60, "brcall_pc");
    expect_out(F_TOP, 32'h44, "brcall_top");
    expect_out(F_CNT, 32'h1, "brcall_cnt");
    tick();
    ret_step(32'h999, 32'h44, 0, 0);

    // Call / return.
    redirect_to(32'h100, 0);
    call_step(32'h400, 32'h104, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 32'h999);
    expect_out(F_PC, 32'h104, "ret1_pc");
    expect_out(F_CNT, 32'h0, "ret1_cnt");
    expect_out(F_TOP, 32'h0, "ret1_top");
    expect_out(F_EMPTY, 32'h1, "ret1_empty");
    tick();

    // Overflow wrap: five calls push 0x4..0x14 from PC 0.
    redirect_to(32'h0, 0);
    call_step(32'h4,  32'h4,  1, 0);
    call_step(32'h8,  32'h8,  2, 0);
    call_step(32'hC,  32'hC,  3, 0);
    call_step(32'h10, 32'h10, 4, 0);
    call_step(32'h14, 32'h14, 4, 1);
    ret_step(32'h999, 32'h14, 3, 0);
    ret_step(32'h999, 32'h10, 2, 0);
    ret_step(32'h999, 32'hC,  1, 0);
    ret_step(32'h999, 32'h8,  0, 0);
    ret_step(32'h600, 32'h600, 0, 1);

    // Simultaneous call+ret: build top=0x200, count=2 at PC=0x300.
    redirect_to(32'hFC, 1);
    call_step(32'h1FC, 32'h100, 1, 1);
    call_step(32'h300, 32'h200, 2, 1);
    drive(0, 1, 0, 0, 0, 0, 1, 1, 32'h500);
    expect_out(F_PC, 32'h500, "callret_pc");
    expect_out(F_TOP, 32'h304, "callret_top");
    expect_out(F_CNT, 32'h2, "callret_cnt");
    tick();

    // Flush beats the push; sticky flags survive the flush.
    drive(0, 1, 0, 0, 1, 0, 1, 0, 32'h700);
    expect_out(F_PC, 32'h700, "flush_pc");
    expect_out(F_CNT, 32'h0, "flush_cnt");
    expect_out(F_EMPTY, 32'h1, "flush_empty");
    expect_out(F_OVF, 32'h1, "flush_ovf");
    expect_out(F_UNF, 32'h1, "flush_unf");
    tick();

    // Call+ret on an empty stack is a plain push without underflow.
    // (Sticky unf is already 1, so check count/top only.)
    drive(0, 1, 0, 0, 0, 0, 1, 1, 32'h800);
    expect_out(F_PC, 32'h800, "callret_empty_pc");
    expect_out(F_TOP, 32'h704, "callret_empty_top");
    expect_out(F_CNT, 32'h1, "callret_empty_cnt");
    tick();

    // npc wrap at 2^32.
    redirect_to(32'hFFFF_FFFC, 0);
    expect_out(F_NPC, 32'h0, "wrap_npc");
    tick();
    seq_step(32'h0);

    // Mid-operation reset with three entries and ovf set.
    call_step(32'h900, 32'h4,  2, 1);
    call_step(32'hA00, 32'h904, 3, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hBBB);
    expect_out(F_PC, 32'h0, "mrst_pc");
    expect_out(F_CNT, 32'h0, "mrst_cnt");
    expect_out(F_TOP, 32'h0, "mrst_top");
    expect_out(F_OVF, 32'h0, "mrst_ovf");
    expect_out(F_UNF, 32'h0, "mrst_unf");
    expect_out(F_EMPTY, 32'h1, "mrst_empty");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the fetch stage, the successor to the single-register PC.
- Holds the fetch PC and selects the next PC from four sources: sequential increment, taken branch/jump target, call target, and return prediction.
- Contains a circular return-address stack (RAS) that predicts return targets.
- Supports stall (pc_en low), pipeline redirect (flush/exception/mispredict), which overrides stall, and a stack flush.

Parameters:
PC_W, 32, width of PC and all address ports
RESET_PC, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential increment added to PC
RAS_DEPTH, 4, RAS entries; power of two, >= 2
CNT_W, $clog2(RAS_DEPTH)+1, derived width of ras_count (localparam, not overridable)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
pc_en  in  1  advance PC this cycle (0 = stall)
redirect_en  in  1  force PC to redirect_pc; highest priority; ignores pc_en
redirect_pc  in  PC_W  redirect target
ras_flush  in  1  empty the RAS this cycle
branch_en  in  1  taken branch/jump; next PC = target_pc
call_en  in  1  call; push PC+INC, next PC = target_pc
ret_en  in  1  return; pop RAS, next PC = predicted address
target_pc  in  PC_W  decoded branch/call target; fallback for ret on empty RAS
PC  out  PC_W  current fetch PC (registered)
npc  out  PC_W  PC+INC (combinational)
ras_top  out  PC_W  entry at top of stack; 0 when empty
ras_count  out  CNT_W  valid entries, 0..RAS_DEPTH
ras_empty  out  1  ras_count == 0
ras_ovf  out  1  sticky: a push occurred while the stack was full
ras_unf  out  1  sticky: a pop occurred while the stack was empty

Behaviour:
Reset (RST=1 at a CLK edge):
- PC=RESET_PC, ras_count=0, stack pointer=0, ras_ovf=0, ras_unf=0.
- Stack contents are don't-care; ras_top reads 0.
- Reset overrides every other input in that cycle.

Arithmetic:
- npc = PC+INC, truncated to PC_W (wraps at 2^PC_W, e.g. 0xFFFF_FFFC -> 0x0000_0000).

Next-PC priority, applied at the clock edge:
1. redirect_en: PC <= redirect_pc. All RAS push/pop is suppressed (squashed instruction). Only ras_flush may still act.
2. pc_en=0: PC holds. No RAS change except ras_flush.
3. ret_en & !call_en & !ras_empty: PC <= ras_top, then pop.
4. ret_en & !call_en & ras_empty: PC <= target_pc, ras_unf <= 1, count stays 0.
5. ret_en & call_en: PC <= target_pc. Top entry is replaced with npc; count and pointer are unchanged. On an empty stack this acts as a push and does not set ras_unf.
6. call_en only: PC <= target_pc, then push npc.
7. branch_en only: PC <= target_pc.
8. Otherwise: PC <= npc.
- branch_en asserted together with call_en or ret_en is ignored; the call/ret rule applies.

RAS rules:
- Organisation: circular buffer with a top pointer.
- Push: pointer increments mod RAS_DEPTH, the entry is written, count increments and saturates at RAS_DEPTH.
- Push when full: the oldest entry is overwritten and ras_ovf <= 1.
- Pop: pointer decrements mod RAS_DEPTH, count decrements.
- A new ras_top is visible the cycle after the push/pop edge.
- ras_flush: count <= 0 and pointer <= 0. It takes priority over any push/pop in the same cycle and applies regardless of pc_en or redirect_en.
- ras_flush does not clear the sticky flags; only RST clears them.
- No combinational path from any input to PC. npc depends only on PC.

Test Plan:
- Reset/sequential: RST high 1 cycle, then pc_en=1 for 3 cycles -> PC 0x0, 0x4, 0x8, 0xC; npc always PC+4; ras_empty=1.
- Stall vs redirect: PC=0x10, pc_en=0 for 2 cycles -> PC stays 0x10. Then pc_en=0, redirect_en=1, redirect_pc=0x80 with call_en=1 -> PC=0x80, ras_count stays 0.
- Call/return: PC=0x100, call_en, target_pc=0x400 -> PC=0x400, ras_top=0x104, count=1. Next, ret_en with target_pc=0x999 -> PC=0x104, count=0.
- Overflow wrap: RAS_DEPTH=4, five calls pushing 0x4, 0x8, 0xC, 0x10, 0x14 -> count=4, ras_ovf=1. Four returns then yield 0x14, 0x10, 0xC, 0x8; a fifth return -> PC=target_pc, ras_unf=1.
- Simultaneous call+ret: stack top=0x200, count=2, call_en=ret_en=1 at PC=0x300, target_pc=0x500 -> PC=0x500, ras_top=0x304, count=2. ras_flush with call_en same cycle -> count=0.
- Mid-operation reset: stack count=3, ras_ovf=1, assert RST together with ret_en -> PC=RESET_PC, count=0, ras_ovf=0, ras_unf=0.
